// File: rtl/display_pkg.sv
// Shared constants, state encoding and nibble sanitizer for the display share arbiter.
package display_pkg;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [7:0] BLANK_BCD    = 8'hFF;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The downstream 7-seg driver blanks anything above 9; force it to the canonical blank code.
    function automatic logic [3:0] sanitize_nibble(input logic [3:0] n);
        return (n > 4'd9) ? BLANK_NIBBLE : n;
    endfunction

endpackage

// File: rtl/display_rr_pick.sv
// Combinational round-robin picker: first valid index scanning from i_ptr upward, modulo N_REQ.
// Latency: zero (pure combinational); no backpressure of its own.
module display_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_any_valid
);

    int               w_idx;
    logic             w_found;
    logic [N_REQ-1:0] w_shift;

    assign o_any_valid = |i_valid;

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_shift = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_shift = i_valid >> w_idx;
            if (!w_found && w_shift[0]) begin
                w_found = 1'b1;
                o_pick  = N_REQ'(1) << w_idx;
            end
        end
    end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin share of the 2-digit 7-seg display; bcd_o updates 1 cycle after accept and is held HOLD_CYCLES.
// Ready is offered only in ARB; optional requester-0 preemption via DISPLAY_ARB_PREEMPT_EN.
module display_share_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 27000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_bcd_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         bcd_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               bad_bcd_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_bcd;
    logic [N_REQ-1:0] r_grant;
    logic             r_busy;
    logic             r_bad;

    logic [N_REQ-1:0] w_pick;
    logic             w_any;
    logic [N_REQ-1:0] w_sel;
    logic             w_preempt;
    logic             w_accept;
    logic [PW-1:0]    w_g;
    logic [PW-1:0]    w_next_ptr;
    logic [7:0]       w_raw;
    logic [7:0]       w_clean;
    logic             w_bad;

    display_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .i_valid     (req_valid_i),
        .i_ptr       (r_ptr),
        .o_pick      (w_pick),
        .o_any_valid (w_any)
    );

`ifdef DISPLAY_ARB_PREEMPT_EN
    // Requester 0 is urgent: it wins ARB outright and cuts short anyone else's hold.
    assign w_sel     = req_valid_i[0] ? N_REQ'(1) : w_pick;
    assign w_preempt = (r_state == HOLD) && req_valid_i[0] && !r_grant[0];
`else
    assign w_sel     = w_pick;
    assign w_preempt = 1'b0;
`endif

    // Gated by reset so ready reads 0 the instant reset asserts, even with valids pending.
    assign w_accept    = (r_state == ARB) && w_any && rst_i;
    assign req_ready_o = w_accept ? w_sel : '0;

    always_comb begin
        w_g   = '0;
        w_raw = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel[i]) begin
                w_g   = PW'(i);
                w_raw = req_bcd_i[8*i +: 8];
            end
        end
    end

    assign w_next_ptr = (w_g == PW'(N_REQ - 1)) ? '0 : w_g + PW'(1);
    assign w_clean    = {sanitize_nibble(w_raw[7:4]), sanitize_nibble(w_raw[3:0])};
    assign w_bad      = (w_clean != w_raw);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_bcd   <= BLANK_BCD;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_bad <= 1'b0;
            case (r_state)
                ARB: begin
                    if (w_accept) begin
                        r_bcd   <= w_clean;
                        r_bad   <= w_bad;
                        r_grant <= w_sel;
                        r_ptr   <= w_next_ptr;
                        r_cnt   <= CW'(HOLD_CYCLES - 1);
                        r_busy  <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0 || w_preempt) begin
                        r_busy  <= 1'b0;
                        r_state <= ARB;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign bcd_o     = r_bcd;
    assign grant_o   = r_grant;
    assign busy_o    = r_busy;
    assign bad_bcd_o = r_bad;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter (N_REQ=2, HOLD_CYCLES=4), directed scenarios plus random vs model.
module tb_display_share_arbiter;

    localparam int N    = 2;
    localparam int HOLD = 4;

    logic         clk_i;
    logic         rst_i;
    logic [1:0]   req_valid_i;
    logic [15:0]  req_bcd_i;
    logic [1:0]   req_ready_o;
    logic [7:0]   bcd_o;
    logic [1:0]   grant_o;
    logic         busy_o;
    logic         bad_bcd_o;

    int checks;
    int failures;

    display_share_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_bcd_i   (req_bcd_i),
        .req_ready_o (req_ready_o),
        .bcd_o       (bcd_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .bad_bcd_o   (bad_bcd_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b0;
        req_valid_i = 2'b00;
        req_bcd_i   = 16'h0000;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bcd_o !== 8'hFF) begin failures++; $display("FAIL reset_bcd got=%h exp=ff", bcd_o); end
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        req_bcd_i   = 16'h0055;
        req_valid_i = 2'b11;
        @(negedge clk_i);
        checks++; if (bcd_o !== 8'h55) begin failures++; $display("FAIL pre_reset_bcd got=%h exp=55", bcd_o); end
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checks++; if (bcd_o !== 8'hFF) begin failures++; $display("FAIL async_reset_bcd got=%h exp=ff", bcd_o); end
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL async_reset_grant got=%b exp=00", grant_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy_o); end
        checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL async_reset_ready got=%b exp=00", req_ready_o); end
        @(negedge clk_i);
        rst_i       = 1'b1;
        req_valid_i = 2'b00;
    endtask

    task automatic test_single();
        int busy_cnt;
        do_reset();
        req_bcd_i   = 16'h0042;
        req_valid_i = 2'b01;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        checks++; if (bcd_o !== 8'h42) begin failures++; $display("FAIL single_bcd got=%h exp=42", bcd_o); end
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant_o); end
        checks++; if (bad_bcd_o !== 1'b0) begin failures++; $display("FAIL single_bad got=%b exp=0", bad_bcd_o); end
        checks++; if (req_ready_o !== 2'b00) begin failures++; $display("FAIL single_ready_drop got=%b exp=00", req_ready_o); end
        busy_cnt = busy_o ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
        end
        checks++; if (busy_cnt != HOLD) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, HOLD); end
        checks++; if (bcd_o !== 8'h42 || grant_o !== 2'b01) begin failures++; $display("FAIL single_keep got=%h/%b exp=42/01", bcd_o, grant_o); end
    endtask

    task automatic test_fairness();
        int   last;
        int   exp_idx;
        int   n_acc;
        logic pend;
        logic [7:0] pend_bcd;
        logic [1:0] pend_grant;
        do_reset();
        req_bcd_i   = 16'h2211;
        req_valid_i = 2'b11;
        last = -1; exp_idx = 0; n_acc = 0; pend = 1'b0; pend_bcd = 8'h00; pend_grant = 2'b00;
        for (int c = 0; c < 21; c++) begin
            #1;
            if (pend) begin
                checks++; if (bcd_o !== pend_bcd || grant_o !== pend_grant) begin
                    failures++; $display("FAIL fair_bcd c=%0d got=%h/%b exp=%h/%b", c, bcd_o, grant_o, pend_bcd, pend_grant);
                end
                pend = 1'b0;
            end
            if (req_ready_o != 2'b00) begin
                checks++; if (req_ready_o !== (2'b01 << exp_idx)) begin
                    failures++; $display("FAIL fair_order c=%0d got=%b exp_idx=%0d", c, req_ready_o, exp_idx);
                end
                if (last >= 0) begin
                    checks++; if (c - last != HOLD + 1) begin failures++; $display("FAIL fair_spacing got=%0d exp=%0d", c - last, HOLD + 1); end
                end
                pend       = 1'b1;
                pend_bcd   = (exp_idx == 0) ? 8'h11 : 8'h22;
                pend_grant = 2'b01 << exp_idx;
                last       = c;
                exp_idx    = 1 - exp_idx;
                n_acc++;
            end
            @(negedge clk_i);
        end
        req_valid_i = 2'b00;
        checks++; if (n_acc != 5) begin failures++; $display("FAIL fair_count got=%0d exp=5", n_acc); end
    endtask

    task automatic test_bad_bcd();
        do_reset();
        req_bcd_i   = 16'h003C;
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        checks++; if (bcd_o !== 8'h3F) begin failures++; $display("FAIL bad_bcd_value got=%h exp=3f", bcd_o); end
        checks++; if (bad_bcd_o !== 1'b1) begin failures++; $display("FAIL bad_bcd_pulse got=%b exp=1", bad_bcd_o); end
        @(negedge clk_i);
        checks++; if (bad_bcd_o !== 1'b0) begin failures++; $display("FAIL bad_bcd_width got=%b exp=0", bad_bcd_o); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req_bcd_i   = 16'h0012;
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_hold_busy got=%b exp=1", busy_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (bcd_o !== 8'hFF || grant_o !== 2'b00 || busy_o !== 1'b0) begin
            failures++; $display("FAIL mid_hold_reset got=%h/%b/%b exp=ff/00/0", bcd_o, grant_o, busy_o);
        end
        req_bcd_i   = 16'h7700;
        req_valid_i = 2'b10;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL mid_hold_rearb got=%b exp=10", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        checks++; if (bcd_o !== 8'h77 || grant_o !== 2'b10) begin
            failures++; $display("FAIL mid_hold_accept got=%h/%b exp=77/10", bcd_o, grant_o);
        end
    endtask

    task automatic test_preempt();
        int hit;
        int exp_hit;
`ifdef DISPLAY_ARB_PREEMPT_EN
        exp_hit = 2;
`else
        exp_hit = HOLD + 1;
`endif
        do_reset();
        req_bcd_i   = 16'h5566;
        req_valid_i = 2'b10;
        hit = -1;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) req_valid_i = 2'b11;
            #1;
            if (c == 0) begin
                checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL preempt_first got=%b exp=10", req_ready_o); end
            end
            if (hit >= 0 && c == hit + 1) begin
                checks++; if (bcd_o !== 8'h66 || grant_o !== 2'b01) begin
                    failures++; $display("FAIL preempt_bcd got=%h/%b exp=66/01", bcd_o, grant_o);
                end
                req_valid_i = 2'b00;
            end
            if (c > 0 && hit < 0 && req_ready_o[0]) hit = c;
            @(negedge clk_i);
        end
        req_valid_i = 2'b00;
        checks++; if (hit != exp_hit) begin failures++; $display("FAIL preempt_timing got=%0d exp=%0d", hit, exp_hit); end
    endtask

    task automatic test_random();
        int         m_ptr;
        int         m_hold;
        logic [7:0] m_bcd;
        logic [1:0] m_grant;
        logic       m_bad;
        logic [1:0] v;
        logic [15:0] b;
        logic [1:0] exp_rdy;
        int         g;
        int         idx;
        int         tt;
        int         uu;
        logic [7:0] raw;
        do_reset();
        m_ptr = 0; m_hold = 0; m_bcd = 8'hFF; m_grant = 2'b00; m_bad = 1'b0;
        for (int n = 0; n < 400; n++) begin
            checks++; if (bcd_o !== m_bcd || grant_o !== m_grant || busy_o !== (m_hold != 0) || bad_bcd_o !== m_bad) begin
                failures++;
                $display("FAIL rand_out n=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", n, bcd_o, grant_o, busy_o, bad_bcd_o,
                         m_bcd, m_grant, (m_hold != 0), m_bad);
            end
            v = 2'($urandom_range(0, 3));
            b = 16'($urandom);
            req_valid_i = v;
            req_bcd_i   = b;
            #1;
            g = -1;
            if (m_hold == 0) begin
`ifdef DISPLAY_ARB_PREEMPT_EN
                if (v[0]) g = 0;
`endif
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && v[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
            checks++; if (req_ready_o !== exp_rdy) begin
                failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, req_ready_o, exp_rdy);
            end
            m_bad = 1'b0;
            if (g >= 0) begin
                raw = (g == 0) ? b[7:0] : b[15:8];
                tt  = int'(raw) / 16;
                uu  = int'(raw) % 16;
                if (tt > 9) tt = 15;
                if (uu > 9) uu = 15;
                m_bcd   = 8'(tt * 16 + uu);
                m_bad   = (m_bcd != raw);
                m_grant = 2'b01 << g;
                m_ptr   = (g + 1) % N;
                m_hold  = HOLD;
            end else if (m_hold > 0) begin
`ifdef DISPLAY_ARB_PREEMPT_EN
                if (v[0] && !m_grant[0]) m_hold = 0;
                else m_hold = m_hold - 1;
`else
                m_hold = m_hold - 1;
`endif
            end
            @(negedge clk_i);
        end
        req_valid_i = 2'b00;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_i       = 1'b0;
        req_valid_i = 2'b00;
        req_bcd_i   = 16'h0000;
        test_reset();
        test_single();
        test_fairness();
        test_bad_bcd();
        test_reset_mid_hold();
        test_preempt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
